alu_rr_arbiter: RTL and testbench

- Shares a single 4-bit ALU instance (func codes: ADD=0, SUB=1, INV=2, AND=3, OR=4, XOR=5, LESS=6, EQ=7) between NREQ requesters.
- Round-robin arbitration; one operation in flight at a time; valid/ready handshake on both request and response sides.
- Sits between datapath clients (e.g. decode and test harness) and the ALU. Drives the ALU operand/func ports from registers and captures result/Z/L into a held response.

---
 rtl/alu_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter
//
// Round-robin front end that lets NREQ clients share one combinational 4-bit
// ALU. Only one operation is in flight at a time: a request is accepted in
// IDLE, presented to the ALU for exactly one cycle (EXEC), and its result is
// held in a response register until the consumer takes it (RESP).
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_valid/ready   : per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b       : 4-bit operands, requester i at bits [4i+3:4i]
//   req_func          : 3-bit ALU function, requester i at bits [3i+2:3i]
//   rsp_valid/ready   : response handshake
//   rsp_id            : index of the requester that issued the operation
//   rsp_result/z/l    : ALU result and flags captured at the end of EXEC
//   alu_a/b/func      : operands to the shared ALU, driven from op registers
//   alu_result/z/l    : combinational ALU outputs
//   busy              : high whenever an operation is in flight
//
// Parameters
//   NREQ : number of requesters, 2..4
//   IDW  : response ID width, 2**IDW >= NREQ
// ---------------------------------------------------------------------------

// Protocol checker: kept apart from the datapath so it can be dropped or
// rebound without touching the arbiter itself.
module alu_rr_arbiter_checker #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input logic            clk,
    input logic            rst_n,
    input logic [NREQ-1:0] req_ready,
    input logic            busy,
    input logic            rsp_valid,
    input logic            rsp_ready,
    input logic [IDW-1:0]  rsp_id,
    input logic [3:0]      rsp_result,
    input logic            rsp_z,
    input logic            rsp_l
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_no_grant_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (req_ready == '0));

    a_rsp_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> busy);

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable({rsp_id, rsp_result, rsp_z, rsp_l})));

endmodule

module alu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_func,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_result,
    output logic              rsp_z,
    output logic              rsp_l,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_func,
    input  logic [3:0]        alu_result,
    input  logic              alu_z,
    input  logic              alu_l,
    output logic              busy
);

    localparam int PW  = $clog2(NREQ);
    localparam int OPW = 4;
    localparam int FNW = 3;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   rr_ptr_r;
    logic [PW-1:0]   rr_ptr_next_s;
    logic [3:0]      op_a_r;
    logic [3:0]      op_b_r;
    logic [2:0]      op_func_r;
    logic [IDW-1:0]  op_id_r;
    logic            grant_found_s;
    logic [PW-1:0]   grant_idx_s;
    logic            accept_s;
    logic            rsp_done_s;

    // Round-robin search starting at ptr. The loop walks from the farthest
    // candidate to the nearest so the nearest valid requester overwrites
    // everything else and is the one returned. Result is {found, index}.
    function automatic logic [PW:0] rr_search(input logic [NREQ-1:0] valid,
                                              input logic [PW-1:0]   ptr);
        logic [PW:0]     pick;
        logic [NREQ-1:0] rot;
        int              idx;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            rot = valid >> idx;
            if (rot[0]) begin
                pick = {1'b1, PW'(idx)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Grant selection from the current pointer
    always_comb begin
        {grant_found_s, grant_idx_s} = rr_search(req_valid, rr_ptr_r);
    end

    // Handshake qualifiers
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && grant_found_s;
        rsp_done_s = (state_r == ST_RESP) && rsp_ready;
    end

    // Grant strobe: only in IDLE, and forced low while reset is applied
    always_comb begin
        req_ready = '0;
        if (rst_n && accept_s) begin
            req_ready = ONE_HOT0 << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer advances past the winner on every accept, wrapping at NREQ
    always_comb begin
        rr_ptr_next_s = rr_ptr_r;
        if (accept_s) begin
            if (grant_idx_s == PW'(NREQ - 1)) begin
                rr_ptr_next_s = '0;
            end else begin
                rr_ptr_next_s = grant_idx_s + PW'(1'b1);
            end
        end else begin
            rr_ptr_next_s = rr_ptr_r;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_next_s;
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

    // Operand registers: request fields are sampled only on the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r    <= '0;
            op_b_r    <= '0;
            op_func_r <= '0;
            op_id_r   <= '0;
        end else if (accept_s) begin
            op_a_r    <= 4'(req_a >> (int'(grant_idx_s) * OPW));
            op_b_r    <= 4'(req_b >> (int'(grant_idx_s) * OPW));
            op_func_r <= 3'(req_func >> (int'(grant_idx_s) * FNW));
            op_id_r   <= IDW'(grant_idx_s);
        end else begin
            op_a_r    <= op_a_r;
            op_b_r    <= op_b_r;
            op_func_r <= op_func_r;
            op_id_r   <= op_id_r;
        end
    end

    // Response register: capture ALU outputs at the end of EXEC, hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_l      <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= op_id_r;
            rsp_result <= alu_result;
            rsp_z      <= alu_z;
            rsp_l      <= alu_l;
        end else if (rsp_done_s) begin
            rsp_valid  <= 1'b0;
        end else begin
            rsp_valid  <= rsp_valid;
        end
    end

    // The ALU sees the operand registers directly, so its inputs stay stable
    // from EXEC through RESP.
    assign alu_a    = op_a_r;
    assign alu_b    = op_b_r;
    assign alu_func = op_func_r;
    assign busy     = (state_r != ST_IDLE);

    alu_rr_arbiter_checker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_ready  (req_ready),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_z      (rsp_z),
        .rsp_l      (rsp_l)
    );

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed scenarios followed by random traffic,
// checked by a reference model that predicts grants and response timing and
// queues expected responses for a separate response monitor.
module tb_alu_rr_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_SUB  = 3'd1;
    localparam logic [2:0] F_INV  = 3'd2;
    localparam logic [2:0] F_AND  = 3'd3;
    localparam logic [2:0] F_OR   = 3'd4;
    localparam logic [2:0] F_XOR  = 3'd5;
    localparam logic [2:0] F_LESS = 3'd6;
    localparam logic [2:0] F_EQ   = 3'd7;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [3:0]     res;
        logic           z;
        logic           l;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_func;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_result;
    logic              rsp_z;
    logic              rsp_l;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_func;
    logic [3:0]        alu_result;
    logic              alu_z;
    logic              alu_l;
    logic              busy;

    int   vectors = 0;
    int   miscompares = 0;
    rsp_t exp_q[$];
    rsp_t got_q[$];

    // model state: cycles since the last accept (0 = nothing in flight)
    int         since_m = 0;
    int         rr_m = 0;
    logic [3:0] cur_a = 4'd0;
    logic [3:0] cur_b = 4'd0;
    logic [2:0] cur_f = 3'd0;

    logic            held_v = 1'b0;
    rsp_t            held;
    logic [NREQ-1:0] acc;
    int              order[4];
    int              ng;

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_z      (rsp_z),
        .rsp_l      (rsp_l),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_l      (alu_l),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared combinational ALU
    always_comb begin
        alu_result = 4'd0;
        alu_z      = 1'b0;
        alu_l      = 1'b0;
        case (alu_func)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = ~alu_a;
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a ^ alu_b;
            3'd6: alu_l = (alu_a < alu_b);
            3'd7: alu_z = (alu_a == alu_b);
            default: alu_result = 4'd0;
        endcase
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Expected response from the function table, in plain integer arithmetic
    function automatic rsp_t ref_op(input int id, input int a, input int b, input int f);
        rsp_t r;
        r.id  = IDW'(id);
        r.res = 4'd0;
        r.z   = 1'b0;
        r.l   = 1'b0;
        case (f)
            0: r.res = 4'((a + b) % 16);
            1: r.res = 4'((a - b + 16) % 16);
            2: r.res = 4'(15 - a);
            3: r.res = 4'(a & b);
            4: r.res = 4'(a | b);
            5: r.res = 4'(a ^ b);
            6: r.l = (a < b);
            7: r.z = (a == b);
            default: r.res = 4'd0;
        endcase
        return r;
    endfunction

    // Reference model: grant prediction, busy/rsp_valid timing, ALU operands
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        int g;
        exp_ready = '0;
        g = -1;
        if (!rst_n) begin
            since_m = 0;
            rr_m = 0;
            exp_q.delete();
            check("reset_req_ready", 32'(req_ready), 32'(0));
            check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
            check("reset_busy", 32'(busy), 32'(0));
            check("reset_alu", 32'({alu_a, alu_b, alu_func}), 32'(0));
        end else begin
            if (since_m == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(since_m != 0));
            check("rsp_valid", 32'(rsp_valid), 32'(since_m >= 2));
            if (since_m != 0) check("alu_operands", 32'({alu_a, alu_b, alu_func}), 32'({cur_a, cur_b, cur_f}));
            if (g >= 0) begin
                cur_a = req_a[4*g +: 4];
                cur_b = req_b[4*g +: 4];
                cur_f = req_func[3*g +: 3];
                exp_q.push_back(ref_op(g, int'(cur_a), int'(cur_b), int'(cur_f)));
                rr_m = (g + 1) % NREQ;
                since_m = 1;
            end else if (since_m == 1) begin
                since_m = 2;
            end else if (since_m == 2 && rsp_ready) begin
                since_m = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each response handshake
    always @(negedge clk) begin
        rsp_t act;
        rsp_t e;
        act = {rsp_id, rsp_result, rsp_z, rsp_l};
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("rsp_hold", 32'(act), 32'(held));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", 32'(act), 32'(e));
                end
                got_q.push_back(act);
            end
            held_v = rsp_valid && !rsp_ready;
            held = act;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] f);
        req_valid[i]     = v;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_func[3*i +: 3] = f;
    endtask

    // Present a request and hold it until accepted; returns in the EXEC cycle
    task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        logic ok;
        ok = 1'b0;
        drive_req(i, 1'b1, a, b, f);
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            ok = req_ready[i];
            step();
        end
        req_valid[i] = 1'b0;
        check("accept_timeout", 32'(ok), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_func  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_fields", 32'({rsp_id, rsp_result, rsp_z, rsp_l}), 32'(0));
        step();
        rst_n = 1'b1;
        step();

        // single op: ADD 9+8 wraps to 1, two-edge latency
        rsp_ready = 1'b1;
        got_q.delete();
        issue(0, 4'd9, 4'd8, F_ADD);
        @(negedge clk);
        check("single_busy_exec", 32'(busy), 32'(1));
        check("single_rsp_early", 32'(rsp_valid), 32'(0));
        step();
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'(1));
        check("single_result", 32'(rsp_result), 32'(1));
        check("single_id", 32'(rsp_id), 32'(0));
        check("single_flags", 32'({rsp_z, rsp_l}), 32'(0));
        step();
        @(negedge clk);
        check("single_busy_done", 32'(busy), 32'(0));
        step();

        // pointer: req1 alone, INV 5 = 10; pointer wraps back to 0
        got_q.delete();
        issue(1, 4'd5, 4'd0, F_INV);
        repeat (4) step();
        check("ptr_rsp_count", 32'(got_q.size()), 32'(1));
        if (got_q.size() > 0) begin
            check("ptr_result", 32'(got_q[0].res), 32'(10));
            check("ptr_id", 32'(got_q[0].id), 32'(1));
        end

        // contention: both valid continuously, grants alternate from 0
        got_q.delete();
        drive_req(0, 1'b1, 4'd3, 4'd5, F_SUB);
        drive_req(1, 1'b1, 4'd6, 4'd6, F_EQ);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                order[ng] = 0;
                ng++;
            end else if (req_ready[1]) begin
                order[ng] = 1;
                ng++;
            end
            step();
        end
        req_valid = '0;
        check("cont_grant_count", 32'(ng), 32'(4));
        for (int k = 0; k < ng; k++) check("cont_order", 32'(order[k]), 32'(k % 2));
        repeat (4) step();
        check("cont_rsp_count", 32'(got_q.size()), 32'(4));
        if (got_q.size() >= 2) begin
            check("cont_rsp0", 32'({got_q[0].id, got_q[0].res}), 32'({2'd0, 4'd14}));
            check("cont_rsp1", 32'({got_q[1].id, got_q[1].res, got_q[1].z}), 32'({2'd1, 4'd0, 1'b1}));
        end

        // backpressure: LESS 2,7 held while req1 waits
        got_q.delete();
        rsp_ready = 1'b0;
        issue(0, 4'd2, 4'd7, F_LESS);
        drive_req(1, 1'b1, 4'd1, 4'd1, F_ADD);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            check("bp_rsp", 32'({rsp_result, rsp_l, rsp_z}), 32'({4'd0, 1'b1, 1'b0}));
            check("bp_req_ready", 32'(req_ready), 32'(0));
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_req_ready", 32'(req_ready), 32'(0));
        step();
        @(negedge clk);
        check("bp_accept_after", 32'(req_ready), 32'(2));
        step();
        req_valid[1] = 1'b0;
        repeat (4) step();
        check("bp_rsp_count", 32'(got_q.size()), 32'(2));
        if (got_q.size() >= 2) check("bp_second", 32'({got_q[1].id, got_q[1].res}), 32'({2'd1, 4'd2}));

        // reset during EXEC discards the op
        got_q.delete();
        issue(0, 4'd12, 4'd10, F_XOR);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        check("rst_no_rsp", 32'(got_q.size()), 32'(0));
        issue(1, 4'd12, 4'd10, F_AND);
        repeat (3) step();
        check("rst_after_count", 32'(got_q.size()), 32'(1));
        if (got_q.size() > 0) check("rst_after_rsp", 32'({got_q[0].id, got_q[0].res}), 32'({2'd1, 4'd8}));

        // idle: nothing valid for 10 cycles, then pointer still favours req0
        repeat (10) step();
        drive_req(0, 1'b1, 4'd7, 4'd9, F_OR);
        drive_req(1, 1'b1, 4'd1, 4'd2, F_SUB);
        @(negedge clk);
        check("idle_ptr_grant", 32'(req_ready), 32'(1));
        step();
        req_valid[0] = 1'b0;
        issue(1, 4'd1, 4'd2, F_SUB);
        repeat (4) step();

        // random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(2) != 0) begin
                        drive_req(i, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)),
                                  3'($urandom_range(7)));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        check("drain_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
